if_stage: RTL

- Instruction-fetch stage of the 5-stage RV32I pipeline.
- Holds the PC, drives a synchronous-read (BRAM, 1-cycle latency) instruction memory, selects the next PC, and owns the IF/ID pipeline register.
- Consumes pc_en / if_id_en from the forwarding-hazard unit and the npc_mux_sel redirect from EX.
- Produces id_is, which feeds decode and the forwarding-hazard unit.

---
 rtl/riscv_pkg.sv | 33 +++
 rtl/if_pc_gen.sv | 45 ++++
 rtl/if_stage.sv | 139 +++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, the canonical NOP, next-PC select
// encodings and the fetch-stage FSM state type.
package riscv_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_JAL  = 2'b10;
    localparam logic [1:0] NPC_JALR = 2'b11;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } if_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_pc_gen.sv
// Next-PC selection for the fetch stage: boot vector, EX redirect targets
// (word-aligned), stall hold or sequential pc+4, plus the BRAM read enable.
module if_pc_gen
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        boot,
    input  logic [31:0] pc,
    input  logic        pc_en,
    input  logic [1:0]  npc_mux_sel,
    input  logic [31:0] br_target,
    input  logic [31:0] jal_target,
    input  logic [31:0] jalr_target,
    output logic [31:0] next_pc,
    output logic        im_en,
    output logic        redirect
);

    logic [31:0] target;

    always_comb begin
        target   = br_target;
        redirect = (npc_mux_sel != NPC_PC4);
        case (npc_mux_sel)
            NPC_BR:   target = br_target;
            NPC_JAL:  target = jal_target;
            NPC_JALR: target = jalr_target & ~32'h1;
            default:  target = br_target;
        endcase

        // Boot beats redirect beats stall beats sequential fetch.
        if (boot)
            next_pc = RESET_PC;
        else if (redirect)
            next_pc = word_align(target);
        else if (!pc_en)
            next_pc = pc;
        else
            next_pc = pc + 32'd4;

        im_en = boot | redirect | pc_en;
    end

endmodule

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: PC register, BRAM fetch, IF/ID register.
// Optional IF_PERF_CNT_EN macro adds saturating stall/flush counters.
module if_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IM_AW    = 10
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             pc_en,
    input  logic             if_id_en,
    input  logic [1:0]       npc_mux_sel,
    input  logic [31:0]      br_target,
    input  logic [31:0]      jal_target,
    input  logic [31:0]      jalr_target,
    output logic [IM_AW-1:0] im_addr,
    output logic             im_en,
    input  logic [31:0]      im_rdata,
    output logic [31:0]      if_pc,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_pc4,
    output logic [31:0]      id_is,
    output logic             id_valid,
    output logic [31:0]      perf_stall_cnt,
    output logic [31:0]      perf_flush_cnt
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] id_is_q, id_is_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] next_pc;
    logic        redirect;
    logic        boot;

    assign boot = (state_q == ST_BOOT);

    if_pc_gen #(.RESET_PC(RESET_PC)) u_pc_gen (
        .boot        (boot),
        .pc          (pc_q),
        .pc_en       (pc_en),
        .npc_mux_sel (npc_mux_sel),
        .br_target   (br_target),
        .jal_target  (jal_target),
        .jalr_target (jalr_target),
        .next_pc     (next_pc),
        .im_en       (im_en),
        .redirect    (redirect)
    );

    assign im_addr = next_pc[IM_AW+1:2];

    always_comb begin
        state_d    = ST_RUN;
        // pc only moves when the BRAM is read, keeping pc and im_rdata paired.
        pc_d       = im_en ? next_pc : pc_q;
        id_is_d    = id_is_q;
        id_pc_d    = id_pc_q;
        id_pc4_d   = id_pc4_q;
        id_valid_d = id_valid_q;
        if (boot || redirect) begin
            id_is_d    = NOP_INSN;
            id_valid_d = 1'b0;
        end else if (if_id_en) begin
            id_is_d    = im_rdata;
            id_pc_d    = pc_q;
            id_pc4_d   = pc_q + 32'd4;
            id_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            id_is_q    <= NOP_INSN;
            id_pc_q    <= 32'd0;
            id_pc4_q   <= 32'd0;
            id_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            id_is_q    <= id_is_d;
            id_pc_q    <= id_pc_d;
            id_pc4_q   <= id_pc4_d;
            id_valid_q <= id_valid_d;
        end
    end

    assign if_pc    = pc_q;
    assign id_is    = id_is_q;
    assign id_pc    = id_pc_q;
    assign id_pc4   = id_pc4_q;
    assign id_valid = id_valid_q;

    // Hazard unit must never advance the PC while freezing IF/ID.
    a_no_pc_adv_with_ifid_hold : assert property (
        @(posedge clk) disable iff (!rstn)
        (!boot && !redirect) |-> !(pc_en && !if_id_en)
    );

`ifdef IF_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!boot && !pc_en && !redirect)
            stall_cnt_d = sat_inc(stall_cnt_q);
        if (redirect)
            flush_cnt_d = sat_inc(flush_cnt_q);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_flush_cnt = 32'd0;
`endif

endmodule
